// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: runs one shared 1-bit full-subtractor cell
// LSB-first over WIDTH cycles, with a start/busy/done handshake and held results.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] sr_next;

    // The shared 1-bit full-subtractor cell, fed from the operand LSBs and the borrow register.
    assign cell_diff   = sa[0] ^ sb[0] ^ br;
    assign cell_borrow = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign sr_next     = {cell_diff, sr[WIDTH-1:1]};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    br  <= cell_borrow;
                    sr  <= sr_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    // Results are loaded only here, so they hold through IDLE and the next RUN.
                    if (cnt == LAST) begin
                        diff  <= sr_next;
                        bout  <= cell_borrow;
                        zero  <= (sr_next == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed cases at WIDTH=8, exhaustive
// sweep at WIDTH=4, and a cycle-by-cycle comparison against an arithmetic model.
module tb_serial_sub_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic       s8   = 1'b0;
    logic [7:0] a8   = '0;
    logic [7:0] b8   = '0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, zero8;
    logic [7:0] diff8;

    logic       s4   = 1'b0;
    logic [3:0] a4   = '0;
    logic [3:0] b4   = '0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, zero4;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt8  = 0;
    int last_done8 = 0;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
    );

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .zero(zero4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an operation is "cycles left" plus a result worked out by plain arithmetic.
    typedef struct {
        int     left;
        bit     done;
        longint diff;
        bit     bout;
        bit     zero;
        longint pdiff;
        bit     pbout;
    } model_t;

    function automatic model_t model_clear();
        model_t m;
        m.left = 0; m.done = 1'b0; m.diff = 0; m.bout = 1'b0; m.zero = 1'b0;
        m.pdiff = 0; m.pbout = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m, input int w, input bit start,
                                          input longint a, input longint b, input bit bin);
        model_t n;
        longint d;
        n = m;
        if (m.left > 0) begin
            n.left = m.left - 1;
            if (n.left == 0) begin
                n.done = 1'b1;
                n.diff = m.pdiff;
                n.bout = m.pbout;
                n.zero = (m.pdiff == 0);
            end
        end else begin
            n.done = 1'b0;
            if (start) begin
                d       = a - b - longint'(bin);
                n.left  = w;
                n.pdiff = d & ((longint'(1) << w) - 1);
                n.pbout = (d < 0);
            end
        end
        return n;
    endfunction

    model_t m8, m4;

    initial begin
        m8 = model_clear();
        m4 = model_clear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m8 = model_clear();
                m4 = model_clear();
            end else begin
                m8 = model_step(m8, 8, s8, longint'(a8), longint'(b8), bin8);
                m4 = model_step(m4, 4, s4, longint'(a4), longint'(b4), bin4);
            end
        end
    end

    // Compare process: every cycle, just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            check("busy8", 64'(busy8), 64'(m8.left > 0));
            check("done8", 64'(done8), 64'(m8.done));
            check("diff8", 64'(diff8), 64'(m8.diff));
            check("bout8", 64'(bout8), 64'(m8.bout));
            check("zero8", 64'(zero8), 64'(m8.zero));
            check("busy4", 64'(busy4), 64'(m4.left > 0));
            check("done4", 64'(done4), 64'(m4.done));
            check("diff4", 64'(diff4), 64'(m4.diff));
            check("bout4", 64'(bout4), 64'(m4.bout));
            check("zero4", 64'(zero4), 64'(m4.zero));
            if (done8 === 1'b1) begin
                done_cnt8++;
                last_done8 = cyc;
            end
        end
    end

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        @(negedge clk);
        s8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        @(negedge clk);
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        @(negedge clk);
        s4 = 1'b1; a4 = a; b4 = b; bin4 = bin;
        @(negedge clk);
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    endtask

    task automatic wait_done8(input string name);
        int n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done8), 64'(1));
    endtask

    task automatic wait_done4(input string name);
        int n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, 64'(done4), 64'(1));
    endtask

    task automatic check_res8(input string name, input logic [7:0] d, input logic bo, input logic z);
        check({name, "_diff"}, 64'(diff8), 64'(d));
        check({name, "_bout"}, 64'(bout8), 64'(bo));
        check({name, "_zero"}, 64'(zero8), 64'(z));
        check({name, "_busy"}, 64'(busy8), 64'(0));
    endtask

    initial begin
        int dc;
        int first_done;
        int e;

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy8), 64'(0));
        check("rst_done", 64'(done8), 64'(0));
        check("rst_diff", 64'(diff8), 64'(0));
        check("rst_bout", 64'(bout8), 64'(0));
        check("rst_zero", 64'(zero8), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic subtract: 0x5A - 0x3C = 0x1E; busy for exactly 8 cycles, then done.
        go8(8'h5A, 8'h3C, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("basic_busy_run", 64'(busy8), 64'(1));
            check("basic_done_run", 64'(done8), 64'(0));
            @(negedge clk);
        end
        check("basic_done", 64'(done8), 64'(1));
        check_res8("basic", 8'h1E, 1'b0, 1'b0);
        check("model_basic_diff", 64'(m8.diff), 64'h1E);
        @(negedge clk);
        check("basic_idle_done", 64'(done8), 64'(0));
        check("basic_hold_diff", 64'(diff8), 64'h1E);

        go8(8'h00, 8'h01, 1'b0);
        wait_done8("underflow");
        check_res8("underflow", 8'hFF, 1'b1, 1'b0);
        check("model_underflow_bout", 64'(m8.bout), 64'(1));

        go8(8'h80, 8'h7F, 1'b1);
        wait_done8("zero");
        check_res8("zero", 8'h00, 1'b0, 1'b1);
        check("model_zero_flag", 64'(m8.zero), 64'(1));

        // A start pulse during RUN must be ignored.
        dc = done_cnt8;
        go8(8'h10, 8'h01, 1'b0);
        @(negedge clk);
        s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0;
        @(negedge clk);
        s8 = 1'b0;
        wait_done8("busyprot");
        check_res8("busyprot", 8'h0F, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("busyprot_one_done", 64'(done_cnt8 - dc), 64'(1));

        // Reset mid-RUN clears everything at once and never yields done.
        go8(8'h33, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy8), 64'(0));
        check("midrst_done", 64'(done8), 64'(0));
        check("midrst_diff", 64'(diff8), 64'(0));
        check("midrst_bout", 64'(bout8), 64'(0));
        check("midrst_zero", 64'(zero8), 64'(0));
        dc = done_cnt8;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt8 - dc), 64'(0));
        go8(8'h03, 8'h05, 1'b0);
        wait_done8("after_rst");
        check_res8("after_rst", 8'hFE, 1'b1, 1'b0);

        // Back-to-back with start held: results one every 9 cycles.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0;
        wait_done8("b2b_first");
        first_done = last_done8;
        check_res8("b2b_first", 8'h05, 1'b0, 1'b0);
        a8 = 8'h04; b8 = 8'h09;
        @(negedge clk);
        s8 = 1'b0;
        check("b2b_rerun_busy", 64'(busy8), 64'(1));
        wait_done8("b2b_second");
        check_res8("b2b_second", 8'hFB, 1'b1, 1'b0);
        check("b2b_spacing", 64'(last_done8 - first_done), 64'(9));

        // Exhaustive sweep at WIDTH=4.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    go4(4'(ia), 4'(ib), 1'(ic));
                    wait_done4("exh");
                    e = ia - ib - ic;
                    check("exh_diff", 64'(diff4), 64'(e & 15));
                    check("exh_bout", 64'(bout4), 64'(e < 0));
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
